// File: rtl/fmaalign_pipe_if.sv
`default_nettype none
//============================================================================
// Module   : fmaalign_pipe_if
// Purpose  : Handshake/data bundle for the pipelined FMA addend aligner.
//            FMAALIGN_PERF_EN adds the performance counter outputs.
// Revision : 1.0 - initial release
//============================================================================
interface fmaalign_pipe_if #(
    parameter int NE   = 11,
    parameter int NF   = 52,
    parameter int TAGW = 4
);
    logic              Flush;
    logic              InValid;
    logic              InReady;
    logic [NE-1:0]     Xe;
    logic [NE-1:0]     Ye;
    logic [NE-1:0]     Ze;
    logic [NF:0]       Zm;
    logic              XZero;
    logic              YZero;
    logic              ZZero;
    logic [TAGW-1:0]   InTag;
    logic              OutValid;
    logic              OutReady;
    logic [3*NF+3:0]   Am;
    logic              ASticky;
    logic              KillProd;
    logic              NFPlusThree;
    logic [TAGW-1:0]   OutTag;
`ifdef FMAALIGN_PERF_EN
    logic [31:0]       PerfKillProd;
    logic [31:0]       PerfKillZ;
    logic [31:0]       PerfStall;
`endif

    modport slave (
        input  Flush, InValid, Xe, Ye, Ze, Zm, XZero, YZero, ZZero, InTag, OutReady,
`ifdef FMAALIGN_PERF_EN
        output PerfKillProd, PerfKillZ, PerfStall,
`endif
        output InReady, OutValid, Am, ASticky, KillProd, NFPlusThree, OutTag
    );

    modport master (
        output Flush, InValid, Xe, Ye, Ze, Zm, XZero, YZero, ZZero, InTag, OutReady,
`ifdef FMAALIGN_PERF_EN
        input  PerfKillProd, PerfKillZ, PerfStall,
`endif
        input  InReady, OutValid, Am, ASticky, KillProd, NFPlusThree, OutTag
    );
endinterface
`default_nettype wire

// File: rtl/fmaalign_pipe.sv
`default_nettype none
//============================================================================
// Module   : fmaalign_pipe
// Purpose  : Two-stage FMA addend alignment (coarse then fine shift) with
//            valid/ready handshake and flush. FMAALIGN_PERF_EN adds counters.
// Revision : 1.0 - initial release
//============================================================================
module fmaalign_pipe #(
    parameter int NE    = 11,
    parameter int NF    = 52,
    parameter int BIAS  = 1023,
    parameter int SPLIT = 3,
    parameter int TAGW  = 4
) (
    input  wire logic        clk,
    input  wire logic        reset,
    fmaalign_pipe_if.slave   bus
);
    localparam int c_CW = NE + 2;
    localparam int c_PW = 4 * NF + 4;
    localparam int c_AW = 3 * NF + 4;
    localparam logic [c_CW-1:0] c_BIAS = c_CW'(BIAS);
    localparam logic [c_CW-1:0] c_NF2  = c_CW'(NF + 2);
    localparam logic [c_CW-1:0] c_KZ   = c_CW'(3 * NF + 3);

    // Handshake
    logic w_s2adv, w_inrdy, w_acc, w_s2ld;
    logic r_s1v, r_ov;

    assign w_s2adv = ~r_ov | bus.OutReady;
    assign w_inrdy = ~r_s1v | w_s2adv | bus.Flush;
    assign w_acc   = bus.InValid & w_inrdy & ~bus.Flush;
    assign w_s2ld  = r_s1v & w_s2adv & ~bus.Flush;

    // Stage 1 combinational: count, kills, coarse shift
    logic [c_CW-1:0]  w_acnt, w_csh;
    logic             w_kp, w_kz;
    logic [c_PW-1:0]  w_pre, w_c, w_c1, w_kp_pat;
    logic [SPLIT-1:0] w_lo1;

    assign w_acnt = {2'b00, bus.Xe} + {2'b00, bus.Ye} - c_BIAS + c_NF2 - {2'b00, bus.Ze};
    assign w_kp   = (w_acnt[c_CW-1] & ~bus.ZZero) | bus.XZero | bus.YZero;
    assign w_kz   = $signed(w_acnt) > $signed(c_KZ);
    assign w_pre  = {bus.Zm, {(3*NF+3){1'b0}}};
    assign w_csh  = {w_acnt[c_CW-1:SPLIT], {SPLIT{1'b0}}};
    assign w_c    = w_pre >> w_csh;
    assign w_kp_pat = {{(NF+2){1'b0}}, bus.Zm, {(2*NF+1){1'b0}}};

    // Kill overrides are folded into the coarse word so stage 2 only shifts;
    // the fine count is zeroed so the override pattern passes through intact.
    always_comb begin
        w_c1  = w_c;
        w_lo1 = w_acnt[SPLIT-1:0];
        if (w_kp) begin
            w_c1  = w_kp_pat;
            w_lo1 = '0;
        end else if (w_kz) begin
            w_c1  = '0;
            w_lo1 = '0;
        end
    end

    logic [c_PW-1:0]  r_c;
    logic [SPLIT-1:0] r_lo;
    logic             r_kp, r_kz, r_xyz, r_zz, r_nf3;
    logic [TAGW-1:0]  r_tag;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_s1v <= 1'b0;
            r_c   <= '0;
            r_lo  <= '0;
            r_kp  <= 1'b0;
            r_kz  <= 1'b0;
            r_xyz <= 1'b0;
            r_zz  <= 1'b0;
            r_nf3 <= 1'b0;
            r_tag <= '0;
        end else begin
            if (bus.Flush)
                r_s1v <= 1'b0;
            else if (w_inrdy)
                r_s1v <= bus.InValid;
            if (w_acc) begin
                r_c   <= w_c1;
                r_lo  <= w_lo1;
                r_kp  <= w_kp;
                r_kz  <= w_kz;
                r_xyz <= bus.XZero | bus.YZero;
                r_zz  <= bus.ZZero;
                r_nf3 <= &w_acnt;
                r_tag <= bus.InTag;
            end
        end
    end

    // Stage 2 combinational: fine shift and sticky
    logic [c_PW-1:0] w_s;
    logic            w_st;

    assign w_s = r_c >> r_lo;

    always_comb begin
        w_st = |w_s[NF-1:0];
        if (r_kp)
            w_st = ~r_xyz;
        else if (r_kz)
            w_st = ~r_zz;
    end

    logic [c_AW-1:0] r_am;
    logic            r_st, r_okp, r_onf3;
    logic [TAGW-1:0] r_otag;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ov   <= 1'b0;
            r_am   <= '0;
            r_st   <= 1'b0;
            r_okp  <= 1'b0;
            r_onf3 <= 1'b0;
            r_otag <= '0;
        end else begin
            if (bus.Flush)
                r_ov <= 1'b0;
            else if (w_s2adv)
                r_ov <= r_s1v;
            if (w_s2ld) begin
                r_am   <= w_s[c_PW-1:NF];
                r_st   <= w_st;
                r_okp  <= r_kp;
                r_onf3 <= r_nf3;
                r_otag <= r_tag;
            end
        end
    end

    assign bus.InReady     = w_inrdy;
    assign bus.OutValid    = r_ov;
    assign bus.Am          = r_am;
    assign bus.ASticky     = r_st;
    assign bus.KillProd    = r_okp;
    assign bus.NFPlusThree = r_onf3;
    assign bus.OutTag      = r_otag;

`ifdef FMAALIGN_PERF_EN
    logic        r_okz;
    logic [31:0] r_pkp, r_pkz, r_pst;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_okz <= 1'b0;
            r_pkp <= '0;
            r_pkz <= '0;
            r_pst <= '0;
        end else begin
            if (w_s2ld)
                r_okz <= r_kz & ~r_kp;
            if (r_ov & bus.OutReady & r_okp & ~&r_pkp)
                r_pkp <= r_pkp + 32'd1;
            if (r_ov & bus.OutReady & r_okz & ~&r_pkz)
                r_pkz <= r_pkz + 32'd1;
            if (r_ov & ~bus.OutReady & ~&r_pst)
                r_pst <= r_pst + 32'd1;
        end
    end

    assign bus.PerfKillProd = r_pkp;
    assign bus.PerfKillZ    = r_pkz;
    assign bus.PerfStall    = r_pst;
`endif
endmodule
`default_nettype wire

// File: tb/tb_fmaalign_pipe.sv
`default_nettype none
//============================================================================
// Module   : tb_fmaalign_pipe
// Purpose  : Self-checking bench for fmaalign_pipe against a single-shift
//            reference model. FMAALIGN_PERF_EN also checks the counters.
// Revision : 1.0 - initial release
//============================================================================
module tb_fmaalign_pipe;
    localparam int NE    = 11;
    localparam int NF    = 52;
    localparam int BIAS  = 1023;
    localparam int SPLIT = 3;
    localparam int TAGW  = 4;
    localparam int AW    = 3 * NF + 4;
    localparam int PW    = 4 * NF + 4;
    localparam int CW    = NE + 2;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fmaalign_pipe_if #(.NE(NE), .NF(NF), .TAGW(TAGW)) b();

    fmaalign_pipe #(.NE(NE), .NF(NF), .BIAS(BIAS), .SPLIT(SPLIT), .TAGW(TAGW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (b)
    );

    typedef struct {
        logic [AW-1:0]   am;
        logic            st;
        logic            kp;
        logic            kz;
        logic            nf3;
        logic [TAGW-1:0] tag;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    logic m_s1v = 1'b0;
    logic m_s2v = 1'b0;
    logic last_acc;
    int   p_kp = 0, p_kz = 0, p_st = 0;

    task automatic chk(input string tag, input logic [AW-1:0] obs, input logic [AW-1:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Reference: evaluate the alignment rules with integer arithmetic and a single wide shift.
    function automatic exp_t model(input logic [NE-1:0] xe, ye, ze, input logic [NF:0] zm,
                                   input logic xz, yz, zz, input logic [TAGW-1:0] tag);
        exp_t e;
        int a, au, as;
        logic [PW-1:0] s;
        a  = int'(xe) + int'(ye) - BIAS + NF + 2 - int'(ze);
        au = ((a % (1 << CW)) + (1 << CW)) % (1 << CW);
        as = (au >= (1 << (CW - 1))) ? au - (1 << CW) : au;
        e.tag = tag;
        e.kp  = ((as < 0) && !zz) || xz || yz;
        e.kz  = !e.kp && (as > 3 * NF + 3);
        e.nf3 = (au == (1 << CW) - 1);
        if (e.kp) begin
            e.am = AW'(zm) << (NF + 1);
            e.st = !(xz || yz);
        end else if (e.kz) begin
            e.am = '0;
            e.st = !zz;
        end else begin
            s    = {zm, {(3*NF+3){1'b0}}} >> au;
            e.am = s[PW-1:NF];
            e.st = |s[NF-1:0];
        end
        return e;
    endfunction

    task automatic step();
        logic adv2, rdy, drained;
        exp_t e;
        #1;
        adv2    = !m_s2v || b.OutReady;
        rdy     = !m_s1v || adv2 || b.Flush;
        drained = m_s2v && b.OutReady;
        chk("InReady", AW'(b.InReady), AW'(rdy));
        chk("OutValid", AW'(b.OutValid), AW'(m_s2v));
        if (m_s2v) begin
            if (q.size() == 0) begin
                chk("unexpected_output", AW'(b.OutValid), AW'(0));
            end else begin
                e = q[0];
                chk("Am", b.Am, e.am);
                chk("ASticky", AW'(b.ASticky), AW'(e.st));
                chk("KillProd", AW'(b.KillProd), AW'(e.kp));
                chk("NFPlusThree", AW'(b.NFPlusThree), AW'(e.nf3));
                chk("OutTag", AW'(b.OutTag), AW'(e.tag));
            end
        end
        if (m_s2v && !b.OutReady) p_st++;
        if (drained && q.size() > 0) begin
            e = q.pop_front();
            if (e.kp) p_kp++;
            else if (e.kz) p_kz++;
        end
        last_acc = 1'b0;
        if (b.Flush) begin
            m_s1v = 1'b0;
            m_s2v = 1'b0;
            q.delete();
        end else begin
            if (adv2) m_s2v = m_s1v;
            if (rdy && b.InValid) begin
                q.push_back(model(b.Xe, b.Ye, b.Ze, b.Zm, b.XZero, b.YZero, b.ZZero, b.InTag));
                last_acc = 1'b1;
            end
            if (rdy) m_s1v = b.InValid;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic [NE-1:0] xe, ye, ze, input logic [NF:0] zm,
                          input logic xz, yz, zz, input logic [TAGW-1:0] tag);
        b.Xe = xe; b.Ye = ye; b.Ze = ze; b.Zm = zm;
        b.XZero = xz; b.YZero = yz; b.ZZero = zz; b.InTag = tag;
    endtask

    task automatic set_rand(input logic [TAGW-1:0] tag);
        int xe, ye, k;
        xe = int'($urandom_range(900, 1150));
        ye = int'($urandom_range(900, 1150));
        k  = int'($urandom_range(0, 200)) - 20;
        set_in(NE'(xe), NE'(ye), NE'(xe + ye - BIAS + NF + 2 - k), NF'(0) + (NF+1)'({$urandom(), $urandom()}),
               ($urandom_range(0, 15) == 0), ($urandom_range(0, 15) == 0),
               ($urandom_range(0, 7) == 0), tag);
    endtask

    task automatic send(input logic [NE-1:0] xe, ye, ze, input logic [NF:0] zm,
                        input logic xz, yz, zz, input logic [TAGW-1:0] tag);
        set_in(xe, ye, ze, zm, xz, yz, zz, tag);
        b.InValid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            if (last_acc) break;
        end
        chk("send_accept", AW'(last_acc), AW'(1));
        b.InValid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_OutValid"}, AW'(b.OutValid), AW'(0));
        chk({tag, "_Am"}, b.Am, AW'(0));
        chk({tag, "_ASticky"}, AW'(b.ASticky), AW'(0));
        chk({tag, "_KillProd"}, AW'(b.KillProd), AW'(0));
        chk({tag, "_NFPlusThree"}, AW'(b.NFPlusThree), AW'(0));
        chk({tag, "_OutTag"}, AW'(b.OutTag), AW'(0));
`ifdef FMAALIGN_PERF_EN
        chk({tag, "_PerfKillProd"}, AW'(b.PerfKillProd), AW'(0));
        chk({tag, "_PerfKillZ"}, AW'(b.PerfKillZ), AW'(0));
        chk({tag, "_PerfStall"}, AW'(b.PerfStall), AW'(0));
`endif
    endtask

    localparam logic [NF:0] ZM_ONES = {(NF+1){1'b1}};

    initial begin
        int sent, k;
        logic done;
        reset = 1'b0;
        b.Flush = 1'b0; b.InValid = 1'b0; b.OutReady = 1'b1;
        set_in('0, '0, '0, '0, 1'b0, 1'b0, 1'b0, '0);
        #2;
        chk_zero_outputs("reset");
        idle(2);
        reset = 1'b1;
        idle(1);

        // Directed alignment cases
        send(11'd1023, 11'd1023, 11'd1023, ZM_ONES, 1'b0, 1'b0, 1'b0, 4'h1);
        idle(3);
        send(11'd1023, 11'd1023, 11'd1123, ZM_ONES, 1'b0, 1'b0, 1'b0, 4'h2);
        send(11'd1023, 11'd1023, 11'd1123, ZM_ONES, 1'b1, 1'b0, 1'b0, 4'h3);
        send(11'd1023, 11'd1023, 11'd823,  ZM_ONES, 1'b0, 1'b0, 1'b0, 4'h4);
        send(11'd1023, 11'd1023, 11'd823,  ZM_ONES, 1'b0, 1'b0, 1'b1, 4'h5);
        send(11'd1023, 11'd1023, 11'd1078, ZM_ONES, 1'b0, 1'b0, 1'b0, 4'h6);
        send(11'd1023, 11'd1023, 11'd918,  (NF+1)'(1), 1'b0, 1'b0, 1'b0, 4'h7);
        idle(3);

        // Count sweep across the kill boundaries
        for (k = -5; k <= 165; k++) begin
            send(11'd1023, 11'd1023, NE'(1077 - k), (NF+1)'({$urandom(), $urandom()}),
                 1'b0, 1'b0, ($urandom_range(0, 9) == 0), TAGW'(k));
        end
        idle(3);

        // Backpressure: 8 tagged inputs, OutReady pattern 1,0,0,1
        sent = 0; done = 1'b0;
        for (int cyc = 0; cyc < 100; cyc++) begin
            b.OutReady = (cyc % 4 == 0) || (cyc % 4 == 3);
            b.InValid  = (sent < 8);
            if (sent < 8) set_rand(TAGW'(sent));
            step();
            if (last_acc) sent++;
            if (sent == 8 && q.size() == 0) begin done = 1'b1; break; end
        end
        chk("backpressure_done", AW'(done), AW'(1));
        b.InValid = 1'b0; b.OutReady = 1'b1;

        // Flush with two entries in flight; the same-cycle input is dropped
        b.OutReady = 1'b0;
        send(11'd1023, 11'd1023, 11'd1023, ZM_ONES, 1'b0, 1'b0, 1'b0, 4'hA);
        send(11'd1023, 11'd1023, 11'd1000, ZM_ONES, 1'b0, 1'b0, 1'b0, 4'hB);
        b.Flush = 1'b1; b.InValid = 1'b1; set_rand(4'hC);
        step();
        b.Flush = 1'b0; b.InValid = 1'b0; b.OutReady = 1'b1;
        idle(4);

        // Random stream with random backpressure and occasional flush
        for (int cyc = 0; cyc < 400; cyc++) begin
            b.OutReady = ($urandom_range(0, 3) != 0);
            b.InValid  = ($urandom_range(0, 3) != 0);
            b.Flush    = ($urandom_range(0, 40) == 0);
            set_rand(TAGW'($urandom()));
            step();
        end
        b.Flush = 1'b0; b.InValid = 1'b0; b.OutReady = 1'b1;
        idle(4);

`ifdef FMAALIGN_PERF_EN
        chk("PerfKillProd", AW'(b.PerfKillProd), AW'(p_kp));
        chk("PerfKillZ", AW'(b.PerfKillZ), AW'(p_kz));
        chk("PerfStall", AW'(b.PerfStall), AW'(p_st));
`endif

        // Asynchronous reset in the middle of a stalled stream
        b.OutReady = 1'b0;
        send(11'd1023, 11'd1023, 11'd1023, ZM_ONES, 1'b0, 1'b0, 1'b0, 4'hD);
        send(11'd1023, 11'd1023, 11'd1123, ZM_ONES, 1'b0, 1'b0, 1'b0, 4'hE);
        idle(1);
        reset = 1'b0;
        #1;
        chk_zero_outputs("async_reset");
        m_s1v = 1'b0; m_s2v = 1'b0; q.delete();
        p_kp = 0; p_kz = 0; p_st = 0;
        b.OutReady = 1'b1;
        idle(1);
        reset = 1'b1;
        send(11'd1023, 11'd1023, 11'd1030, ZM_ONES, 1'b0, 1'b0, 1'b0, 4'h9);
        idle(4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
